// File: rtl/irq_bridge_if.sv
// CPU-side bus of irq_bridge: address, write data, byte enables, read data, bus error.
// The CPU drives through master; the bridge answers through slave.
interface irq_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_rdata;
    logic        bus_err;

    modport master (output cpu_addr, output cpu_wdata, output cpu_we,
                    input  cpu_rdata, input bus_err);
    modport slave  (input  cpu_addr, input cpu_wdata, input cpu_we,
                    output cpu_rdata, output bus_err);
endinterface

// File: rtl/irq_bridge.sv
// CPU-to-device address decoder with an edge/level interrupt controller and a write-miss counter.
// Optional IRQ_BRIDGE_SYNC_EN adds a 2-flop synchroniser in front of every irq_in bit.
module irq_bridge #(
    parameter int          NDEV      = 2,
    parameter int          NIRQ      = 6,
    parameter int          WIN_AW    = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic                 clk,
    input  logic                 reset,
    irq_bridge_if.slave          cpu,
    output logic [WIN_AW-1:0]    dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [4*NDEV-1:0]    dev_we,
    input  logic [32*NDEV-1:0]   dev_rdata,
    input  logic [NIRQ-1:0]      irq_in,
    output logic [NIRQ-1:0]      hwint
);
    localparam logic [WIN_AW-1:0] OFF_PEND = WIN_AW'(4'h0);
    localparam logic [WIN_AW-1:0] OFF_MASK = WIN_AW'(4'h4);
    localparam logic [WIN_AW-1:0] OFF_MODE = WIN_AW'(4'h8);
    localparam logic [WIN_AW-1:0] OFF_ERR  = WIN_AW'(4'hC);

    logic [31:0]     off_s, idx_s, bm_s, wbm_s, dev_rd_s, ctl_rd_s;
    logic            ctl_hit_s, miss_s, wr_s;
    logic [NIRQ-1:0] s_s, clr_s;
    logic [NIRQ-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, prev_q;
    logic [7:0]      err_q, err_d;

    assign off_s     = cpu.cpu_addr - BASE_ADDR;
    assign idx_s     = off_s >> WIN_AW;
    assign ctl_hit_s = (idx_s == 32'(NDEV));
    assign miss_s    = (idx_s > 32'(NDEV));
    assign wr_s      = (cpu.cpu_we != 4'h0);
    assign dev_addr  = cpu.cpu_addr[WIN_AW-1:0];
    assign dev_wdata = cpu.cpu_wdata;
    assign bm_s      = {{8{cpu.cpu_we[3]}}, {8{cpu.cpu_we[2]}}, {8{cpu.cpu_we[1]}}, {8{cpu.cpu_we[0]}}};
    assign wbm_s     = cpu.cpu_wdata & bm_s;

`ifdef IRQ_BRIDGE_SYNC_EN
    logic [NIRQ-1:0] sync1_q, sync2_q;

    // Two-stage synchroniser for asynchronous interrupt requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end
    assign s_s = sync2_q;
`else
    assign s_s = irq_in;
`endif

    // Device strobe steering and read-data mux
    always_comb begin
        dev_we   = '0;
        dev_rd_s = 32'h0;
        for (int i = 0; i < NDEV; i++) begin
            dev_we[4*i +: 4] = (idx_s == 32'(i)) ? cpu.cpu_we : 4'h0;
            dev_rd_s = dev_rd_s | ((idx_s == 32'(i)) ? dev_rdata[32*i +: 32] : 32'h0);
        end
        case (dev_addr)
            OFF_PEND: ctl_rd_s = 32'(pend_q);
            OFF_MASK: ctl_rd_s = 32'(mask_q);
            OFF_MODE: ctl_rd_s = 32'(mode_q);
            OFF_ERR:  ctl_rd_s = {24'h0, err_q};
            default:  ctl_rd_s = 32'h0;
        endcase
        cpu.cpu_rdata = ctl_hit_s ? ctl_rd_s : dev_rd_s;
        cpu.bus_err   = wr_s & miss_s;
    end

    // Controller next state; edge sources keep a new edge over a simultaneous clear
    always_comb begin
        clr_s  = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        err_d  = err_q;
        if (ctl_hit_s && dev_addr == OFF_PEND) clr_s = wbm_s[NIRQ-1:0];
        else                                   clr_s = '0;
        if (ctl_hit_s && dev_addr == OFF_MASK) mask_d = (mask_q & ~bm_s[NIRQ-1:0]) | wbm_s[NIRQ-1:0];
        else                                   mask_d = mask_q;
        if (ctl_hit_s && dev_addr == OFF_MODE) mode_d = (mode_q & ~bm_s[NIRQ-1:0]) | wbm_s[NIRQ-1:0];
        else                                   mode_d = mode_q;
        pend_d = (mode_q & ((pend_q & ~clr_s) | (s_s & ~prev_q))) | (~mode_q & s_s);
        if (ctl_hit_s && wr_s && dev_addr == OFF_ERR)  err_d = 8'h00;
        else if (wr_s && miss_s && err_q != 8'hFF)     err_d = err_q + 8'd1;
        else                                           err_d = err_q;
    end

    // Controller state registers and the registered interrupt vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            prev_q <= '0;
            err_q  <= 8'h00;
            hwint  <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            prev_q <= s_s;
            err_q  <= err_d;
            hwint  <= pend_q & mask_q;
        end
    end
endmodule
